rvfi_commit_tracker: RTL and testbench

Producer side of the RVFI commit interface. It sits beside the ROB in the out-of-order core and captures per-instruction RVFI fields from dispatch, writeback and the LSU into a ROB-indexed table. At commit it emits up to COMMIT_W retired instructions per cycle, in program order and with monotonically increasing order numbers, on the per-channel RVFI bus consumed by the testbench monitor and commit-log writer.

---
 rtl/rvfi_pkg.sv | 52 +++++
 rtl/rvfi_commit_tracker_table.sv | 117 +++++++++++
 rtl/rvfi_commit_tracker.sv | 182 ++++++++++++++++++
 tb/tb_rvfi_commit_tracker.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI commit tracker: the per-slot table entry and the
// registered per-channel output record.
package rvfi_pkg;

    localparam int ORDER_W = 64;

    typedef struct packed {
        logic        alloc;
        logic        wb_done;
        logic        mem_done;
        logic        needs_mem;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ORDER_W-1:0] order;
        logic [31:0]        inst;
        logic [31:0]        pc_rdata;
        logic [31:0]        pc_wdata;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [4:0]         rd_addr;
        logic [31:0]        rs1_rdata;
        logic [31:0]        rs2_rdata;
        logic [31:0]        rd_wdata;
        logic [31:0]        mem_addr;
        logic [3:0]         mem_rmask;
        logic [3:0]         mem_wmask;
        logic [31:0]        mem_rdata;
        logic [31:0]        mem_wdata;
    } rvfi_chan_t;

    // Sequential PC: 32-bit encodings have inst[1:0] == 2'b11, anything else is compressed.
    function automatic logic [31:0] default_next_pc(input logic [31:0] pc, input logic [31:0] inst);
        return (inst[1:0] == 2'b11) ? pc + 32'd4 : pc + 32'd2;
    endfunction

endpackage

// File: rtl/rvfi_commit_tracker_table.sv
// ROB-indexed table of captured RVFI fields with dispatch, writeback and LSU
// write ports, plus one bypassed read port per commit channel.
module rvfi_entry_table
    import rvfi_pkg::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int COMMIT_W  = 2,
    parameter int NUM_WB    = 2,
    localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       dis_valid_i,
    input  logic [IDX_W-1:0]           dis_idx_i,
    input  logic [31:0]                dis_pc_i,
    input  logic [31:0]                dis_inst_i,
    input  logic [4:0]                 dis_rs1_addr_i,
    input  logic [4:0]                 dis_rs2_addr_i,
    input  logic [4:0]                 dis_rd_addr_i,
    input  logic                       dis_needs_mem_i,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]    wb_idx_i,
    input  logic [NUM_WB*32-1:0]       wb_rs1_rdata_i,
    input  logic [NUM_WB*32-1:0]       wb_rs2_rdata_i,
    input  logic [NUM_WB*32-1:0]       wb_rd_wdata_i,
    input  logic [NUM_WB-1:0]          wb_pc_wdata_valid_i,
    input  logic [NUM_WB*32-1:0]       wb_pc_wdata_i,
    input  logic                       mem_valid_i,
    input  logic [IDX_W-1:0]           mem_idx_i,
    input  logic [31:0]                mem_addr_i,
    input  logic [3:0]                 mem_rmask_i,
    input  logic [3:0]                 mem_wmask_i,
    input  logic [31:0]                mem_rdata_i,
    input  logic [31:0]                mem_wdata_i,
    input  logic [COMMIT_W-1:0]        commit_valid_i,
    input  logic [COMMIT_W*IDX_W-1:0]  commit_idx_i,
    input  logic                       flush_i,
    output rvfi_entry_t [COMMIT_W-1:0] rd_entry_o,
    output logic                       dis_alloc_o
);

    rvfi_entry_t entries_q [ROB_DEPTH];
    rvfi_entry_t entries_d [ROB_DEPTH];

    // Ports applied in ascending order so the highest-numbered port wins a slot collision.
    function automatic rvfi_entry_t apply_completions(input rvfi_entry_t e, input logic [IDX_W-1:0] idx);
        rvfi_entry_t r;
        r = e;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k] && wb_idx_i[k*IDX_W +: IDX_W] == idx) begin
                r.rs1_rdata = wb_rs1_rdata_i[k*32 +: 32];
                r.rs2_rdata = wb_rs2_rdata_i[k*32 +: 32];
                r.rd_wdata  = wb_rd_wdata_i[k*32 +: 32];
                if (wb_pc_wdata_valid_i[k]) begin
                    r.pc_wdata = wb_pc_wdata_i[k*32 +: 32];
                end
                r.wb_done = 1'b1;
            end
        end
        if (mem_valid_i && mem_idx_i == idx) begin
            r.mem_addr  = mem_addr_i;
            r.mem_rmask = mem_rmask_i;
            r.mem_wmask = mem_wmask_i;
            r.mem_rdata = mem_rdata_i;
            r.mem_wdata = mem_wdata_i;
            r.mem_done  = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            for (int c = 0; c < COMMIT_W; c++) begin
                if (commit_valid_i[c] && commit_idx_i[c*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    entries_d[i].alloc = 1'b0;
                end
            end
            // Dispatch lands after the commit clear so a reused slot ends up allocated.
            if (dis_valid_i && !flush_i && dis_idx_i == IDX_W'(i)) begin
                entries_d[i]           = '0;
                entries_d[i].alloc     = 1'b1;
                entries_d[i].needs_mem = dis_needs_mem_i;
                entries_d[i].pc        = dis_pc_i;
                entries_d[i].inst      = dis_inst_i;
                entries_d[i].rs1_addr  = dis_rs1_addr_i;
                entries_d[i].rs2_addr  = dis_rs2_addr_i;
                entries_d[i].rd_addr   = dis_rd_addr_i;
                entries_d[i].pc_wdata  = default_next_pc(dis_pc_i, dis_inst_i);
            end
            entries_d[i] = apply_completions(entries_d[i], IDX_W'(i));
            if (flush_i) begin
                entries_d[i].alloc = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (!rst_ni) begin
                entries_q[i] <= '0;
            end else begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COMMIT_W; c++) begin
            rd_entry_o[c] = apply_completions(entries_q[commit_idx_i[c*IDX_W +: IDX_W]],
                                              commit_idx_i[c*IDX_W +: IDX_W]);
        end
    end

    assign dis_alloc_o = entries_q[dis_idx_i].alloc;

endmodule

// File: rtl/rvfi_commit_tracker.sv
// RVFI producer: captures per-instruction fields into a ROB-indexed table and
// emits retired instructions in order on registered per-channel outputs.
module rvfi_commit_tracker
    import rvfi_pkg::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int COMMIT_W  = 2,
    parameter int NUM_WB    = 2,
    localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dis_valid,
    input  logic [IDX_W-1:0]             dis_idx,
    input  logic [31:0]                  dis_pc,
    input  logic [31:0]                  dis_inst,
    input  logic [4:0]                   dis_rs1_addr,
    input  logic [4:0]                   dis_rs2_addr,
    input  logic [4:0]                   dis_rd_addr,
    input  logic                         dis_needs_mem,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]      wb_idx,
    input  logic [NUM_WB*32-1:0]         wb_rs1_rdata,
    input  logic [NUM_WB*32-1:0]         wb_rs2_rdata,
    input  logic [NUM_WB*32-1:0]         wb_rd_wdata,
    input  logic [NUM_WB-1:0]            wb_pc_wdata_valid,
    input  logic [NUM_WB*32-1:0]         wb_pc_wdata,
    input  logic                         mem_valid,
    input  logic [IDX_W-1:0]             mem_idx,
    input  logic [31:0]                  mem_addr,
    input  logic [3:0]                   mem_rmask,
    input  logic [3:0]                   mem_wmask,
    input  logic [31:0]                  mem_rdata,
    input  logic [31:0]                  mem_wdata,
    input  logic [COMMIT_W-1:0]          commit_valid,
    input  logic [COMMIT_W*IDX_W-1:0]    commit_idx,
    input  logic                         flush,
    output logic [COMMIT_W-1:0]          rvfi_valid,
    output logic [COMMIT_W*ORDER_W-1:0]  rvfi_order,
    output logic [COMMIT_W*32-1:0]       rvfi_inst,
    output logic [COMMIT_W*32-1:0]       rvfi_pc_rdata,
    output logic [COMMIT_W*32-1:0]       rvfi_pc_wdata,
    output logic [COMMIT_W*32-1:0]       rvfi_rs1_rdata,
    output logic [COMMIT_W*32-1:0]       rvfi_rs2_rdata,
    output logic [COMMIT_W*32-1:0]       rvfi_rd_wdata,
    output logic [COMMIT_W*32-1:0]       rvfi_mem_addr,
    output logic [COMMIT_W*32-1:0]       rvfi_mem_rdata,
    output logic [COMMIT_W*32-1:0]       rvfi_mem_wdata,
    output logic [COMMIT_W*5-1:0]        rvfi_rs1_addr,
    output logic [COMMIT_W*5-1:0]        rvfi_rs2_addr,
    output logic [COMMIT_W*5-1:0]        rvfi_rd_addr,
    output logic [COMMIT_W*4-1:0]        rvfi_mem_rmask,
    output logic [COMMIT_W*4-1:0]        rvfi_mem_wmask,
    output logic                         err
);

    rvfi_entry_t [COMMIT_W-1:0] rd_entry;
    logic                       dis_alloc;
    logic                       dis_hit;
    rvfi_chan_t [COMMIT_W-1:0]  chan_q, chan_d;
    logic [ORDER_W-1:0]         order_q, order_d;
    logic                       err_q, err_d;

    rvfi_entry_table #(
        .ROB_DEPTH (ROB_DEPTH),
        .COMMIT_W  (COMMIT_W),
        .NUM_WB    (NUM_WB)
    ) u_table (
        .clk_i               (clk),
        .rst_ni              (rst),
        .dis_valid_i         (dis_valid),
        .dis_idx_i           (dis_idx),
        .dis_pc_i            (dis_pc),
        .dis_inst_i          (dis_inst),
        .dis_rs1_addr_i      (dis_rs1_addr),
        .dis_rs2_addr_i      (dis_rs2_addr),
        .dis_rd_addr_i       (dis_rd_addr),
        .dis_needs_mem_i     (dis_needs_mem),
        .wb_valid_i          (wb_valid),
        .wb_idx_i            (wb_idx),
        .wb_rs1_rdata_i      (wb_rs1_rdata),
        .wb_rs2_rdata_i      (wb_rs2_rdata),
        .wb_rd_wdata_i       (wb_rd_wdata),
        .wb_pc_wdata_valid_i (wb_pc_wdata_valid),
        .wb_pc_wdata_i       (wb_pc_wdata),
        .mem_valid_i         (mem_valid),
        .mem_idx_i           (mem_idx),
        .mem_addr_i          (mem_addr),
        .mem_rmask_i         (mem_rmask),
        .mem_wmask_i         (mem_wmask),
        .mem_rdata_i         (mem_rdata),
        .mem_wdata_i         (mem_wdata),
        .commit_valid_i      (commit_valid),
        .commit_idx_i        (commit_idx),
        .flush_i             (flush),
        .rd_entry_o          (rd_entry),
        .dis_alloc_o         (dis_alloc)
    );

    always_comb begin
        chan_d  = '0;
        order_d = order_q;
        err_d   = err_q;
        dis_hit = 1'b0;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (commit_valid[c]) begin
                chan_d[c].valid     = 1'b1;
                chan_d[c].order     = order_q + ORDER_W'(c);
                chan_d[c].inst      = rd_entry[c].inst;
                chan_d[c].pc_rdata  = rd_entry[c].pc;
                chan_d[c].pc_wdata  = rd_entry[c].pc_wdata;
                chan_d[c].rs1_addr  = rd_entry[c].rs1_addr;
                chan_d[c].rs2_addr  = rd_entry[c].rs2_addr;
                chan_d[c].rd_addr   = rd_entry[c].rd_addr;
                chan_d[c].rs1_rdata = (rd_entry[c].rs1_addr == 5'd0) ? 32'd0 : rd_entry[c].rs1_rdata;
                chan_d[c].rs2_rdata = (rd_entry[c].rs2_addr == 5'd0) ? 32'd0 : rd_entry[c].rs2_rdata;
                chan_d[c].rd_wdata  = (rd_entry[c].rd_addr == 5'd0) ? 32'd0 : rd_entry[c].rd_wdata;
                chan_d[c].mem_addr  = rd_entry[c].mem_addr;
                chan_d[c].mem_rmask = rd_entry[c].mem_rmask;
                chan_d[c].mem_wmask = rd_entry[c].mem_wmask;
                chan_d[c].mem_rdata = rd_entry[c].mem_rdata;
                chan_d[c].mem_wdata = rd_entry[c].mem_wdata;
                order_d = order_d + ORDER_W'(1);
                if (!rd_entry[c].alloc || !rd_entry[c].wb_done ||
                    (rd_entry[c].needs_mem && !rd_entry[c].mem_done)) begin
                    err_d = 1'b1;
                end
                if (c > 0 && !commit_valid[c-1]) begin
                    err_d = 1'b1;
                end
                for (int c2 = 0; c2 < c; c2++) begin
                    if (commit_valid[c2] && commit_idx[c2*IDX_W +: IDX_W] == commit_idx[c*IDX_W +: IDX_W]) begin
                        err_d = 1'b1;
                    end
                end
                if (commit_idx[c*IDX_W +: IDX_W] == dis_idx) begin
                    dis_hit = 1'b1;
                end
            end
        end
        // A dropped dispatch in a flush cycle never allocates, so it cannot collide.
        if (dis_valid && !flush && dis_alloc && !dis_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            chan_q  <= '0;
            order_q <= '0;
            err_q   <= 1'b0;
        end else begin
            chan_q  <= chan_d;
            order_q <= order_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int c = 0; c < COMMIT_W; c++) begin
            rvfi_valid[c]                      = chan_q[c].valid;
            rvfi_order[c*ORDER_W +: ORDER_W]   = chan_q[c].order;
            rvfi_inst[c*32 +: 32]              = chan_q[c].inst;
            rvfi_pc_rdata[c*32 +: 32]          = chan_q[c].pc_rdata;
            rvfi_pc_wdata[c*32 +: 32]          = chan_q[c].pc_wdata;
            rvfi_rs1_rdata[c*32 +: 32]         = chan_q[c].rs1_rdata;
            rvfi_rs2_rdata[c*32 +: 32]         = chan_q[c].rs2_rdata;
            rvfi_rd_wdata[c*32 +: 32]          = chan_q[c].rd_wdata;
            rvfi_mem_addr[c*32 +: 32]          = chan_q[c].mem_addr;
            rvfi_mem_rdata[c*32 +: 32]         = chan_q[c].mem_rdata;
            rvfi_mem_wdata[c*32 +: 32]         = chan_q[c].mem_wdata;
            rvfi_rs1_addr[c*5 +: 5]            = chan_q[c].rs1_addr;
            rvfi_rs2_addr[c*5 +: 5]            = chan_q[c].rs2_addr;
            rvfi_rd_addr[c*5 +: 5]             = chan_q[c].rd_addr;
            rvfi_mem_rmask[c*4 +: 4]           = chan_q[c].mem_rmask;
            rvfi_mem_wmask[c*4 +: 4]           = chan_q[c].mem_wmask;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Bench for rvfi_commit_tracker: directed scenarios followed by randomized
// ROB-like traffic, all checked against a slot-array reference model.
module tb_rvfi_commit_tracker;

    localparam int ROB = 16;
    localparam int CW  = 2;
    localparam int NW  = 2;
    localparam int IW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           dis_valid, dis_needs_mem;
    logic [IW-1:0]  dis_idx;
    logic [31:0]    dis_pc, dis_inst;
    logic [4:0]     dis_rs1_addr, dis_rs2_addr, dis_rd_addr;
    logic [NW-1:0]  wb_valid, wb_pc_wdata_valid;
    logic [NW*IW-1:0] wb_idx;
    logic [NW*32-1:0] wb_rs1_rdata, wb_rs2_rdata, wb_rd_wdata, wb_pc_wdata;
    logic           mem_valid;
    logic [IW-1:0]  mem_idx;
    logic [31:0]    mem_addr, mem_rdata, mem_wdata;
    logic [3:0]     mem_rmask, mem_wmask;
    logic [CW-1:0]  commit_valid;
    logic [CW*IW-1:0] commit_idx;
    logic           flush;

    logic [CW-1:0]    rvfi_valid;
    logic [CW*64-1:0] rvfi_order;
    logic [CW*32-1:0] rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [CW*32-1:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [CW*5-1:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [CW*4-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic             err;

    rvfi_commit_tracker #(.ROB_DEPTH(ROB), .COMMIT_W(CW), .NUM_WB(NW)) dut (
        .clk(clk), .rst(rst),
        .dis_valid(dis_valid), .dis_idx(dis_idx), .dis_pc(dis_pc), .dis_inst(dis_inst),
        .dis_rs1_addr(dis_rs1_addr), .dis_rs2_addr(dis_rs2_addr), .dis_rd_addr(dis_rd_addr),
        .dis_needs_mem(dis_needs_mem),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
        .wb_rd_wdata(wb_rd_wdata), .wb_pc_wdata_valid(wb_pc_wdata_valid), .wb_pc_wdata(wb_pc_wdata),
        .mem_valid(mem_valid), .mem_idx(mem_idx), .mem_addr(mem_addr), .mem_rmask(mem_rmask),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .commit_valid(commit_valid), .commit_idx(commit_idx), .flush(flush),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask), .err(err)
    );

    // Reference model: one record per ROB slot plus the retire counter.
    logic        m_alloc [ROB], m_wb [ROB], m_mem [ROB], m_nm [ROB];
    logic [31:0] m_pc [ROB], m_inst [ROB], m_pcw [ROB], m_rs1d [ROB], m_rs2d [ROB], m_rdd [ROB];
    logic [31:0] m_maddr [ROB], m_mrd [ROB], m_mwd [ROB];
    logic [4:0]  m_rs1a [ROB], m_rs2a [ROB], m_rda [ROB];
    logic [3:0]  m_rm [ROB], m_wm [ROB];
    logic [63:0] m_order;
    logic        m_err;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst, pc_rdata, pc_wdata, rs1d, rs2d, rdd;
        logic [14:0] regs;
        logic [31:0] maddr;
        logic [7:0]  masks;
        logic [31:0] mrd, mwd;
    } exp_t;
    exp_t ex [CW];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        dis_valid = 0; dis_idx = '0; dis_pc = '0; dis_inst = '0; dis_needs_mem = 0;
        dis_rs1_addr = '0; dis_rs2_addr = '0; dis_rd_addr = '0;
        wb_valid = '0; wb_idx = '0; wb_rs1_rdata = '0; wb_rs2_rdata = '0; wb_rd_wdata = '0;
        wb_pc_wdata_valid = '0; wb_pc_wdata = '0;
        mem_valid = 0; mem_idx = '0; mem_addr = '0; mem_rmask = '0; mem_wmask = '0;
        mem_rdata = '0; mem_wdata = '0;
        commit_valid = '0; commit_idx = '0; flush = 0;
    endtask

    task automatic drv_dis(input int idx, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic nm);
        dis_valid = 1; dis_idx = IW'(idx); dis_pc = pc; dis_inst = inst;
        dis_rs1_addr = rs1; dis_rs2_addr = rs2; dis_rd_addr = rd; dis_needs_mem = nm;
    endtask

    task automatic drv_wb(input int k, input int idx, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] rd, input logic pcv, input logic [31:0] pcw);
        wb_valid[k] = 1; wb_idx[k*IW +: IW] = IW'(idx);
        wb_rs1_rdata[k*32 +: 32] = r1; wb_rs2_rdata[k*32 +: 32] = r2; wb_rd_wdata[k*32 +: 32] = rd;
        wb_pc_wdata_valid[k] = pcv; wb_pc_wdata[k*32 +: 32] = pcw;
    endtask

    task automatic drv_mem(input int idx, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                           input logic [31:0] rdat, input logic [31:0] wdat);
        mem_valid = 1; mem_idx = IW'(idx); mem_addr = a; mem_rmask = rm; mem_wmask = wm;
        mem_rdata = rdat; mem_wdata = wdat;
    endtask

    task automatic drv_commit(input int c, input int idx);
        commit_valid[c] = 1; commit_idx[c*IW +: IW] = IW'(idx);
    endtask

    // Predict this cycle's outputs from the model, update the model, clock once, compare.
    task automatic step();
        logic [CW-1:0] ev;
        logic          err_n, hit, in_rst, vwb, vmem;
        int            ncv, s, d;
        exp_t          x;
        ev = '0; ncv = 0; err_n = m_err; in_rst = !rst;
        if (!in_rst) begin
            for (int c = 0; c < CW; c++) begin
                if (commit_valid[c]) begin
                    s = int'(commit_idx[c*IW +: IW]);
                    x.inst = m_inst[s]; x.pc_rdata = m_pc[s]; x.pc_wdata = m_pcw[s];
                    x.rs1d = m_rs1d[s]; x.rs2d = m_rs2d[s]; x.rdd = m_rdd[s];
                    x.regs = {m_rs1a[s], m_rs2a[s], m_rda[s]};
                    x.maddr = m_maddr[s]; x.masks = {m_rm[s], m_wm[s]}; x.mrd = m_mrd[s]; x.mwd = m_mwd[s];
                    vwb = m_wb[s]; vmem = m_mem[s];
                    for (int k = 0; k < NW; k++) begin
                        if (wb_valid[k] && int'(wb_idx[k*IW +: IW]) == s) begin
                            x.rs1d = wb_rs1_rdata[k*32 +: 32]; x.rs2d = wb_rs2_rdata[k*32 +: 32];
                            x.rdd = wb_rd_wdata[k*32 +: 32]; vwb = 1;
                            if (wb_pc_wdata_valid[k]) x.pc_wdata = wb_pc_wdata[k*32 +: 32];
                        end
                    end
                    if (mem_valid && int'(mem_idx) == s) begin
                        x.maddr = mem_addr; x.masks = {mem_rmask, mem_wmask};
                        x.mrd = mem_rdata; x.mwd = mem_wdata; vmem = 1;
                    end
                    if (m_rs1a[s] == 0) x.rs1d = 0;
                    if (m_rs2a[s] == 0) x.rs2d = 0;
                    if (m_rda[s] == 0) x.rdd = 0;
                    x.order = m_order + 64'(c);
                    ex[c] = x; ev[c] = 1; ncv++;
                    if (!m_alloc[s] || !vwb || (m_nm[s] && !vmem)) err_n = 1;
                    if (c > 0 && !commit_valid[c-1]) err_n = 1;
                    for (int c2 = 0; c2 < c; c2++)
                        if (commit_valid[c2] && commit_idx[c2*IW +: IW] == commit_idx[c*IW +: IW]) err_n = 1;
                end
            end
            d = int'(dis_idx);
            if (dis_valid && !flush && m_alloc[d]) begin
                hit = 0;
                for (int c = 0; c < CW; c++)
                    if (commit_valid[c] && int'(commit_idx[c*IW +: IW]) == d) hit = 1;
                if (!hit) err_n = 1;
            end
            for (int c = 0; c < CW; c++)
                if (commit_valid[c]) m_alloc[int'(commit_idx[c*IW +: IW])] = 0;
            if (dis_valid && !flush) begin
                m_alloc[d] = 1; m_wb[d] = 0; m_mem[d] = 0; m_nm[d] = dis_needs_mem;
                m_pc[d] = dis_pc; m_inst[d] = dis_inst;
                m_rs1a[d] = dis_rs1_addr; m_rs2a[d] = dis_rs2_addr; m_rda[d] = dis_rd_addr;
                m_rs1d[d] = 0; m_rs2d[d] = 0; m_rdd[d] = 0;
                m_maddr[d] = 0; m_rm[d] = 0; m_wm[d] = 0; m_mrd[d] = 0; m_mwd[d] = 0;
                m_pcw[d] = (dis_inst[1:0] == 2'b11) ? dis_pc + 4 : dis_pc + 2;
            end
            for (int k = 0; k < NW; k++) begin
                if (wb_valid[k]) begin
                    s = int'(wb_idx[k*IW +: IW]);
                    m_rs1d[s] = wb_rs1_rdata[k*32 +: 32]; m_rs2d[s] = wb_rs2_rdata[k*32 +: 32];
                    m_rdd[s] = wb_rd_wdata[k*32 +: 32]; m_wb[s] = 1;
                    if (wb_pc_wdata_valid[k]) m_pcw[s] = wb_pc_wdata[k*32 +: 32];
                end
            end
            if (mem_valid) begin
                s = int'(mem_idx);
                m_maddr[s] = mem_addr; m_rm[s] = mem_rmask; m_wm[s] = mem_wmask;
                m_mrd[s] = mem_rdata; m_mwd[s] = mem_wdata; m_mem[s] = 1;
            end
            if (flush) for (int i = 0; i < ROB; i++) m_alloc[i] = 0;
            m_err = err_n;
            m_order = m_order + 64'(ncv);
        end else begin
            for (int i = 0; i < ROB; i++) begin
                m_alloc[i] = 0; m_wb[i] = 0; m_mem[i] = 0;
            end
            m_err = 0; m_order = 0;
        end
        @(posedge clk);
        #1;
        check("valid", 64'(rvfi_valid), 64'(ev));
        check("err", 64'(err), 64'(m_err));
        if (in_rst) begin
            check("rst.outputs_zero", 64'(|{rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
                  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata,
                  rvfi_mem_wdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_mem_rmask,
                  rvfi_mem_wmask}), 64'd0);
        end
        for (int c = 0; c < CW; c++) begin
            if (ev[c]) begin
                check($sformatf("ch%0d.order", c), rvfi_order[c*64 +: 64], ex[c].order);
                check($sformatf("ch%0d.inst", c), 64'(rvfi_inst[c*32 +: 32]), 64'(ex[c].inst));
                check($sformatf("ch%0d.pc_rdata", c), 64'(rvfi_pc_rdata[c*32 +: 32]), 64'(ex[c].pc_rdata));
                check($sformatf("ch%0d.pc_wdata", c), 64'(rvfi_pc_wdata[c*32 +: 32]), 64'(ex[c].pc_wdata));
                check($sformatf("ch%0d.rs1_rdata", c), 64'(rvfi_rs1_rdata[c*32 +: 32]), 64'(ex[c].rs1d));
                check($sformatf("ch%0d.rs2_rdata", c), 64'(rvfi_rs2_rdata[c*32 +: 32]), 64'(ex[c].rs2d));
                check($sformatf("ch%0d.rd_wdata", c), 64'(rvfi_rd_wdata[c*32 +: 32]), 64'(ex[c].rdd));
                check($sformatf("ch%0d.reg_addrs", c), 64'({rvfi_rs1_addr[c*5 +: 5], rvfi_rs2_addr[c*5 +: 5],
                      rvfi_rd_addr[c*5 +: 5]}), 64'(ex[c].regs));
                check($sformatf("ch%0d.mem_addr", c), 64'(rvfi_mem_addr[c*32 +: 32]), 64'(ex[c].maddr));
                check($sformatf("ch%0d.mem_masks", c), 64'({rvfi_mem_rmask[c*4 +: 4], rvfi_mem_wmask[c*4 +: 4]}),
                      64'(ex[c].masks));
                check($sformatf("ch%0d.mem_rdata", c), 64'(rvfi_mem_rdata[c*32 +: 32]), 64'(ex[c].mrd));
                check($sformatf("ch%0d.mem_wdata", c), 64'(rvfi_mem_wdata[c*32 +: 32]), 64'(ex[c].mwd));
            end
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    int q[$];
    int tail, n, ncom, want, didx, s;
    logic dis_on, do_flush;

    initial begin
        rst = 0;
        idle_inputs();
        for (int i = 0; i < ROB; i++) m_alloc[i] = 0;
        m_order = 0; m_err = 0;

        // Reset, then quiet cycles.
        step(); step();
        rst = 1;
        step(); step();
        check("idle.outputs_zero", 64'(|{rvfi_order, rvfi_pc_wdata, rvfi_inst, rvfi_rd_wdata}), 64'd0);

        // Single addi x1,x0,1 retire.
        drv_dis(0, 32'h1eceb000, 32'h00100093, 5'd0, 5'd0, 5'd1, 0); step();
        drv_wb(0, 0, 32'd0, 32'd0, 32'h1, 0, 32'd0); step();
        drv_commit(0, 0); step();
        check("t1.valid", 64'(rvfi_valid), 64'b01);
        check("t1.order", rvfi_order[63:0], 64'd0);
        check("t1.pc_wdata", 64'(rvfi_pc_wdata[31:0]), 64'h1eceb004);
        check("t1.rd", 64'({rvfi_rd_addr[4:0], rvfi_rd_wdata[31:0]}), {27'd0, 5'd1, 32'h1});

        // Dual retire with a compressed instruction in channel 1.
        do_reset();
        drv_dis(1, 32'h000000fc, 32'h00208133, 5'd1, 5'd2, 5'd2, 0); step();
        drv_dis(2, 32'h00000100, 32'h00004501, 5'd0, 5'd0, 5'd10, 0); step();
        drv_wb(0, 1, 32'h11, 32'h22, 32'h33, 0, 32'd0);
        drv_wb(1, 2, 32'h0, 32'h0, 32'h0, 0, 32'd0); step();
        drv_commit(0, 1); drv_commit(1, 2); step();
        check("t2.valid", 64'(rvfi_valid), 64'b11);
        check("t2.order0", rvfi_order[63:0], 64'd0);
        check("t2.order1", rvfi_order[127:64], 64'd1);
        check("t2.c_pc_wdata", 64'(rvfi_pc_wdata[63:32]), 64'h102);

        // Store whose LSU completion arrives in the commit cycle.
        drv_dis(3, 32'h00000102, 32'h00b12023, 5'd2, 5'd11, 5'd0, 1); step();
        drv_wb(1, 3, 32'h1000, 32'hbeef, 32'h0, 0, 32'd0); step();
        drv_commit(0, 3); drv_mem(3, 32'h2000, 4'b0000, 4'b0011, 32'd0, 32'hbeef); step();
        check("t3.order", rvfi_order[63:0], 64'd2);
        check("t3.mem_addr", 64'(rvfi_mem_addr[31:0]), 64'h2000);
        check("t3.wmask_wdata", 64'({rvfi_mem_wmask[3:0], rvfi_mem_wdata[31:0]}), {28'd0, 4'b0011, 32'hbeef});
        check("t3.err", 64'(err), 64'd0);

        // Load retired without its LSU completion.
        drv_dis(4, 32'h00000106, 32'h00012583, 5'd2, 5'd0, 5'd11, 1); step();
        drv_wb(0, 4, 32'h1000, 32'h0, 32'h55, 0, 32'd0); step();
        drv_commit(0, 4); step();
        check("t4.valid", 64'(rvfi_valid), 64'b01);
        check("t4.err", 64'(err), 64'd1);
        step(); step();
        check("t4.err_sticky", 64'(err), 64'd1);

        // Commit with flush, then a stale commit of the flushed slot.
        do_reset();
        drv_dis(5, 32'h00000200, 32'h00100093, 5'd0, 5'd0, 5'd1, 0); step();
        drv_dis(6, 32'h00000204, 32'h00200113, 5'd0, 5'd0, 5'd2, 0); step();
        drv_wb(0, 5, 32'd0, 32'd0, 32'h1, 0, 32'd0);
        drv_wb(1, 6, 32'd0, 32'd0, 32'h2, 0, 32'd0); step();
        drv_commit(0, 5); flush = 1;
        drv_dis(7, 32'h00000208, 32'h00300193, 5'd0, 5'd0, 5'd3, 0); step();
        check("t5.flush_commit_valid", 64'(rvfi_valid), 64'b01);
        check("t5.flush_commit_pc", 64'(rvfi_pc_rdata[31:0]), 64'h200);
        check("t5.err_after_flush", 64'(err), 64'd0);
        drv_commit(0, 6); step();
        check("t5.stale_commit_err", 64'(err), 64'd1);

        // Randomized ROB-like traffic with occasional flushes and one mid-run reset.
        do_reset();
        q.delete(); tail = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                do_reset();
                q.delete(); tail = 0;
            end
            n = q.size(); ncom = 0;
            want = $urandom_range(0, 2);
            for (int c = 0; c < want && c < n; c++) begin
                s = q[c];
                if (!(m_wb[s] && (!m_nm[s] || m_mem[s])) && $urandom_range(0, 49) != 0) break;
                drv_commit(c, s); ncom++;
            end
            do_flush = ($urandom_range(0, 59) == 0);
            flush = do_flush;
            dis_on = 0; didx = tail % ROB;
            if ($urandom_range(0, 1) == 1 && n - ncom < ROB) begin
                dis_on = 1;
                if ($urandom_range(0, 1) == 1)
                    drv_dis(didx, $urandom & 32'hfffffffe, {16'd0, $urandom_range(0, 16'hffff) & 16'hfffc}
                            | 32'($urandom_range(0, 2)), 5'($urandom), 5'($urandom), 5'($urandom),
                            $urandom_range(0, 2) == 0);
                else
                    drv_dis(didx, $urandom & 32'hfffffffc, $urandom | 32'h3, 5'($urandom), 5'($urandom),
                            5'($urandom), $urandom_range(0, 2) == 0);
            end
            for (int k = 0; k < NW; k++) begin
                if (n > 0 && $urandom_range(0, 1) == 1) begin
                    s = q[$urandom_range(0, n - 1)];
                    if (!(dis_on && s == didx))
                        drv_wb(k, s, $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom);
                end
            end
            if (n > 0 && $urandom_range(0, 2) == 0) begin
                s = q[$urandom_range(0, n - 1)];
                if (m_nm[s] && !(dis_on && s == didx))
                    drv_mem(s, $urandom, 4'($urandom), 4'($urandom), $urandom, $urandom);
            end
            for (int c = 0; c < ncom; c++) void'(q.pop_front());
            if (do_flush) q.delete();
            else if (dis_on) begin
                q.push_back(didx); tail++;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
